// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulation stage of the 16-bit MAC unit.
// Each accepted unsigned product is added into a wide accumulator in two
// cycles (low half, then high half plus the registered carry). When the
// product flagged as last has been folded in, the frame result is offered
// on a valid/ready handshake and the accumulator then clears.
// Optional build macro: MAC_SATURATE_EN -- a carry out of the top bit
// pins the accumulator at all-ones for the rest of the frame instead of
// wrapping.
module mac_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam int HALF = ACC_W / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic [HALF-1:0]   prod_hi_q, prod_hi_d;
    logic              last_q, last_d;

    // Product widened to the accumulator width (unsigned, zero-extended).
    logic [ACC_W-1:0]  prod_ext;
    // One extra bit on each half-sum holds the carry out of that half.
    logic [HALF:0]     lo_sum;
    logic [HALF:0]     hi_sum;

    assign prod_ext = ACC_W'(in_prod);
    assign lo_sum   = {1'b0, acc_q[HALF-1:0]} + {1'b0, prod_ext[HALF-1:0]};
    assign hi_sum   = {1'b0, acc_q[ACC_W-1:HALF]} + {1'b0, prod_hi_q}
                    + {{HALF{1'b0}}, carry_q};

    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

    // Next-state, datapath and handshake decode for the three-state frame FSM.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        prod_hi_d = prod_hi_q;
        last_d    = last_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef MAC_SATURATE_EN
                    // A saturated accumulator stays pinned at all-ones.
                    if (!ovf_q) begin
                        acc_d[HALF-1:0] = lo_sum[HALF-1:0];
                    end
`else
                    acc_d[HALF-1:0] = lo_sum[HALF-1:0];
`endif
                    carry_d   = lo_sum[HALF];
                    prod_hi_d = prod_ext[ACC_W-1:HALF];
                    last_d    = in_last;
                    // Term count saturates; saturation is not an overflow.
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    state_d = S_HI;
                end
            end

            S_HI: begin
                acc_d[ACC_W-1:HALF] = hi_sum[HALF-1:0];
                if (hi_sum[HALF]) begin
                    ovf_d = 1'b1;
                end
`ifdef MAC_SATURATE_EN
                if (hi_sum[HALF] || ovf_q) begin
                    acc_d = {ACC_W{1'b1}};
                end
`endif
                state_d = last_q ? S_OUT : S_IDLE;
            end

            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    carry_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            prod_hi_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            prod_hi_q <= prod_hi_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed and randomized frames for mac_accumulator,
// checked against a whole-frame arithmetic reference (exact sum of the
// products, then wrap or saturate at the accumulator width).
module tb_mac_accumulator;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 40;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    int checks = 0;
    int errors = 0;

    // Products of the frame about to be sent.
    bit [31:0] fq[$];

    // Values seen on the last result handshake.
    logic [ACC_W-1:0] got_acc;
    logic [CNT_W-1:0] got_cnt;
    logic             got_ovf;

    mac_accumulator #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prod  (in_prod),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame result from plain arithmetic on the whole product list.
    function automatic void model(output bit [ACC_W-1:0] acc, output bit [CNT_W-1:0] cnt,
                                  output bit ovf);
        bit [63:0] sum;
        sum = 64'd0;
        foreach (fq[i]) sum += 64'(fq[i]);
        cnt = (fq.size() > 255) ? 8'd255 : 8'(fq.size());
        ovf = (sum >= (64'd1 << ACC_W));
`ifdef MAC_SATURATE_EN
        acc = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc = sum[ACC_W-1:0];
`endif
    endfunction

    // Offer one product and return #1 after the edge that accepted it.
    task automatic send(input bit [31:0] p, input bit last);
        int n;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send every product in fq, check latency, result, backpressure and clear.
    task automatic run_frame(input string tag, input int hold);
        bit [ACC_W-1:0] eacc;
        bit [CNT_W-1:0] ecnt;
        bit             eovf;
        int             n;
        model(eacc, ecnt, eovf);
        foreach (fq[i]) send(fq[i], (i == fq.size() - 1));
        check({tag, "_hi_outvalid"}, 64'(out_valid), 64'd0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd1);
        check({tag, "_acc"}, 64'(out_acc), 64'(eacc));
        check({tag, "_count"}, 64'(out_count), 64'(ecnt));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(eovf));
        got_acc = out_acc;
        got_cnt = out_count;
        got_ovf = out_ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_prod  = $urandom;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_acc"}, 64'(out_acc), 64'(eacc));
            check({tag, "_hold_count"}, 64'(out_count), 64'(ecnt));
            check({tag, "_hold_inready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_inready"}, 64'(in_ready), 64'd1);
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_acc"}, 64'(out_acc), 64'd0);
        check({tag, "_post_count"}, 64'(out_count), 64'd0);
        check({tag, "_post_ovf"}, 64'(out_ovf), 64'd0);
        $display("frame %s terms=%0d acc=%010h count=%0d ovf=%0d hold=%0d",
                 tag, fq.size(), got_acc, got_cnt, got_ovf, hold);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_inready", 64'(in_ready), 64'd1);
        check("rst_outvalid", 64'(out_valid), 64'd0);
        check("rst_acc", 64'(out_acc), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_ovf", 64'(out_ovf), 64'd0);

        // Idle with in_valid low stays put.
        repeat (3) @(posedge clk);
        #1;
        check("idle_inready", 64'(in_ready), 64'd1);
        check("idle_count", 64'(out_count), 64'd0);

        // Three equal products.
        fq = {32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001};
        run_frame("three", 0);
        check("three_spec_acc", 64'(got_acc), 64'h02FFFA0003);
        check("three_spec_count", 64'(got_cnt), 64'd3);
        check("three_spec_ovf", 64'(got_ovf), 64'd0);

        // Half-boundary carry, also held under backpressure for 5 cycles.
        fq = {32'h000FFFFF, 32'h00000001};
        run_frame("halfcarry", 5);
        check("halfcarry_spec_acc", 64'(got_acc), 64'h0000100000);

        // Overflow and count saturation.
        fq.delete();
        for (int i = 0; i < 257; i++) fq.push_back(32'hFFFFFFFF);
        run_frame("overflow", 0);
        check("overflow_spec_count", 64'(got_cnt), 64'd255);
        check("overflow_spec_ovf", 64'(got_ovf), 64'd1);
`ifdef MAC_SATURATE_EN
        check("overflow_spec_acc", 64'(got_acc), 64'hFFFFFFFFFF);
`else
        check("overflow_spec_acc", 64'(got_acc), 64'h00FFFFFEFF);
`endif

        // Reset while the second term is in its high-half cycle.
        send(32'h12345678, 1'b0);
        send(32'h9ABCDEF0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_inready", 64'(in_ready), 64'd1);
        check("midrst_outvalid", 64'(out_valid), 64'd0);
        check("midrst_acc", 64'(out_acc), 64'd0);
        check("midrst_count", 64'(out_count), 64'd0);
        check("midrst_ovf", 64'(out_ovf), 64'd0);
        $display("reset mid-frame after 2 terms");
        fq = {32'h00000005};
        run_frame("after_rst", 0);
        check("after_rst_spec_acc", 64'(got_acc), 64'h5);
        check("after_rst_spec_count", 64'(got_cnt), 64'd1);

        // Single zero product still counts as a term.
        fq = {32'h00000000};
        run_frame("zero", 0);
        check("zero_spec_acc", 64'(got_acc), 64'd0);
        check("zero_spec_count", 64'(got_cnt), 64'd1);
        check("zero_spec_ovf", 64'(got_ovf), 64'd0);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            int len;
            len = $urandom_range(1, 8);
            fq.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       fq.push_back(32'h00000000);
                    1:       fq.push_back(32'hFFFFFFFF);
                    default: fq.push_back($urandom);
                endcase
            end
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Accumulation stage of the 16-bit MAC unit. It sits directly downstream of the multiplier and its product adder, and consumes the unsigned 32-bit products they produce.
- Each accepted product is added into a wide accumulator using a two-cycle split addition: low half, then high half plus the registered carry.
- A frame is a sequence of products ending with one flagged as last. At the end of a frame the block presents the result with a valid/ready handshake, then clears for the next frame.

Parameters:
- PROD_W, 32: product width in bits (unsigned).
- ACC_W, 40: accumulator width in bits. Must be even and ≥ PROD_W. HALF = ACC_W/2.
- CNT_W, 8: width of the term counter.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: product present.
- in_ready, output, 1: stage can accept a product.
- in_prod, input, PROD_W: unsigned product; zero-extended to ACC_W.
- in_last, input, 1: marks the final product of the frame.
- out_valid, output, 1: frame result available.
- out_ready, input, 1: downstream accepts the result.
- out_acc, output, ACC_W: accumulated sum.
- out_count, output, CNT_W: number of terms in the frame (saturating).
- out_ovf, output, 1: sticky flag; set if any carry left bit ACC_W-1 during the frame.

Behaviour:
- Reset, checked first every edge, overrides everything:
  - state = S_IDLE; acc, count, carry register and ovf = 0.
  - in_ready = 1; out_valid = 0; out_acc = 0; out_count = 0; out_ovf = 0.
  - A frame in progress is discarded; nothing is emitted.
- States: S_IDLE, S_HI, S_OUT.
- S_IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready:
    - acc[HALF-1:0] <= acc_lo + prod_lo (carry-in 0).
    - Carry out of the low half is stored in the carry register.
    - Zero-extended prod_hi and in_last are latched.
    - count increments, saturating at 2^CNT_W-1.
    - Next state: S_HI.
- S_HI:
  - in_ready = 0.
  - acc[ACC_W-1:HALF] <= acc_hi + prod_hi + carry.
  - A carry out of the top bit sets ovf; acc wraps modulo 2^ACC_W.
  - Next state: S_OUT if the latched last flag is set, otherwise S_IDLE.
- S_OUT:
  - out_valid = 1, in_ready = 0.
  - out_acc, out_count and out_ovf are driven from the registers and held stable while out_ready = 0.
  - On out_ready: acc, count and ovf clear to 0; next state S_IDLE.
- Throughput and latency:
  - One product every 2 cycles.
  - Last product accepted at edge N → out_valid high in the cycle after edge N+1.
  - Back-to-back frames: the next frame's first product is accepted no earlier than the cycle after the result handshake.
- Boundary conditions:
  - in_valid low in S_IDLE → state unchanged.
  - in_prod = 0 still counts as a term.
  - A single-term frame (in_last on the first product) is legal.
  - in_valid is ignored while in_ready = 0; upstream must hold in_prod and in_last stable until accepted.
  - count saturation does not set ovf.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: on a top-bit carry in S_HI, acc is loaded with all-ones instead of the wrapped value. Once ovf = 1, the remaining terms of the frame leave acc at all-ones.
- Not defined: wrap-around modulo 2^ACC_W; ovf still flags the event.

Test Plan:
- Three products 0xFFFE0001, third with in_last → out_valid 2 cycles after the third accept; out_acc = 0x02FFFA0003, out_count = 3, out_ovf = 0.
- Half-boundary carry: 0x000FFFFF then 0x00000001 (last) → out_acc = 0x0000100000; proves the carry register links the halves.
- Overflow: 257 products of 0xFFFFFFFF, last on the 257th → out_count = 255, out_ovf = 1.
  - Without MAC_SATURATE_EN: out_acc = 0x00FFFFFEFF.
  - With MAC_SATURATE_EN: out_acc = 0xFFFFFFFFFF.
- Backpressure: out_ready held 0 for 5 cycles in S_OUT → out_valid and out_acc stable, in_ready = 0. Raise out_ready → next cycle in_ready = 1; the next frame starts from 0.
- Reset mid-frame: accept 2 terms, assert rst in S_HI → next cycle all outputs at reset values. A following single-term frame with 0x5 → out_acc = 0x5, out_count = 1.
- Single-term frame with in_prod = 0 → out_acc = 0, out_count = 1, out_ovf = 0.
